// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider driver.
// Optional period counter is enabled by defining CLK_DIV_DRIVER_PERIOD_CNT_EN.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_e;

  localparam int unsigned MIN_RATIO = 2;

  // Ratios below MIN_RATIO cannot form a high and a low phase.
  function automatic int unsigned clamp_ratio(input int unsigned r);
    return (r < MIN_RATIO) ? MIN_RATIO : r;
  endfunction

endpackage

// File: rtl/clk_div_ratio_hs.sv
// Ratio load/acknowledge handshake: pending ratio, pending-valid flag and ack pulse.
module clk_div_ratio_hs
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_ratio_i,
  input  logic             ratio_ld_i,
  input  logic             apply_win_i,
  output logic [DIV_W-1:0] pend_ratio_o,
  output logic             apply_c,
  output logic             ratio_ack_o
);

  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pv_q, pv_d;
  logic             ack_q, ack_d;

  assign apply_c = pv_q & apply_win_i;

  // A load in the apply cycle re-arms pending with the new value.
  always_comb begin
    pend_d = pend_q;
    pv_d   = pv_q;
    ack_d  = apply_c;
    if (ratio_ld_i) begin
      pend_d = DIV_W'(clamp_ratio(32'(div_ratio_i)));
      pv_d   = 1'b1;
    end else if (apply_c) begin
      pv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= DIV_W'(MIN_RATIO);
      pv_q   <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      pv_q   <= pv_d;
      ack_q  <= ack_d;
    end
  end

  assign pend_ratio_o = pend_q;
  assign ratio_ack_o  = ack_q;

endmodule

// File: rtl/clk_div_driver.sv
// Glitch-free programmable clock divider; ratio/enable changes land on period boundaries.
// Define CLK_DIV_DRIVER_PERIOD_CNT_EN to add the 16-bit period_cnt output.
module clk_div_driver
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W     = 4,
  parameter int unsigned RST_RATIO = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             ratio_ld,
  output logic             ratio_ack,
  output logic             clk_out,
  output logic             busy
`ifdef CLK_DIV_DRIVER_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic             clk_q, clk_d;
  logic             busy_q, busy_d;
  logic [DIV_W-1:0] pend_ratio;
  logic             apply_c;
  logic             running_c;
  logic             wrap_c;

  assign running_c = (state_q != IDLE);
  assign wrap_c    = running_c && (cnt_q == (n_q - DIV_W'(1)));

  clk_div_ratio_hs #(
    .DIV_W (DIV_W)
  ) u_ratio_hs (
    .clk          (CK),
    .rst_n        (RN),
    .div_ratio_i  (div_ratio),
    .ratio_ld_i   (ratio_ld),
    .apply_win_i  ((state_q == IDLE) || wrap_c),
    .pend_ratio_o (pend_ratio),
    .apply_c      (apply_c),
    .ratio_ack_o  (ratio_ack)
  );

  // Next-state, counter, active ratio and output waveform.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    clk_d   = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE:           if (en) state_d = RUN;
      RUN, STOP_PEND: begin
        if (en)          state_d = RUN;
        else if (wrap_c) state_d = IDLE;
        else             state_d = STOP_PEND;
      end
      default:        state_d = IDLE;
    endcase
    cnt_d  = (!running_c || wrap_c) ? '0 : cnt_q + DIV_W'(1);
    clk_d  = running_c && (cnt_q < (n_q >> 1));
    busy_d = (state_d != IDLE);
    if (apply_c) n_d = pend_ratio;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= DIV_W'(clamp_ratio(RST_RATIO));
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      clk_q   <= clk_d;
      busy_q  <= busy_d;
    end
  end

  assign clk_out = clk_q;
  assign busy    = busy_q;

`ifdef CLK_DIV_DRIVER_PERIOD_CNT_EN
  logic [15:0] pc_q, pc_d;

  // Counts completed periods since leaving IDLE.
  always_comb begin
    pc_d = pc_q;
    if (running_c && (state_d == IDLE)) pc_d = '0;
    else if (wrap_c)                    pc_d = pc_q + 16'd1;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign period_cnt = pc_q;
`endif

endmodule

// File: tb/tb_clk_div_driver.sv
// Self-checking bench for clk_div_driver: per-cycle model compare plus directed literals.
module tb_clk_div_driver;

  localparam int unsigned DIV_W     = 4;
  localparam int unsigned RST_RATIO = 2;

  logic             CK = 1'b0;
  logic             RN = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] div_ratio = '0;
  logic             ratio_ld = 1'b0;
  logic             ratio_ack, clk_out, busy;
`ifdef CLK_DIV_DRIVER_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  clk_div_driver #(.DIV_W(DIV_W), .RST_RATIO(RST_RATIO)) dut (
    .CK        (CK),
    .RN        (RN),
    .en        (en),
    .div_ratio (div_ratio),
    .ratio_ld  (ratio_ld),
    .ratio_ack (ratio_ack),
    .clk_out   (clk_out),
    .busy      (busy)
`ifdef CLK_DIV_DRIVER_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 CK = ~CK;

  // Model: mode 0 idle, 1 running, 2 stopping; pos is the cycle index within the period.
  int m_mode = 0, m_pos = 0, m_n = RST_RATIO, m_pend = 2, m_pc = 0, m_nmode;
  bit m_pv = 0, m_clk = 0, m_ack = 0, m_busy = 0, m_wrap, m_apply;

  function automatic int clamp(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_mode = 0; m_pos = 0; m_n = RST_RATIO; m_pend = 2; m_pv = 0;
      m_clk = 0; m_ack = 0; m_busy = 0; m_pc = 0;
    end else begin
      m_wrap  = (m_mode != 0) && (m_pos == m_n - 1);
      m_apply = m_pv && ((m_mode == 0) || m_wrap);
      m_clk   = (m_mode != 0) && (m_pos < m_n / 2);
      m_ack   = m_apply;
      if (en)                        m_nmode = 1;
      else if (m_mode == 0 || m_wrap) m_nmode = 0;
      else                           m_nmode = 2;
      if (m_nmode == 0 && m_mode != 0) m_pc = 0;
      else if (m_wrap)                 m_pc = (m_pc + 1) % 65536;
      m_pos = (m_mode == 0 || m_wrap) ? 0 : m_pos + 1;
      if (m_apply) m_n = m_pend;
      if (ratio_ld) begin m_pend = clamp(int'(div_ratio)); m_pv = 1; end
      else if (m_apply) m_pv = 0;
      m_mode = m_nmode;
      m_busy = (m_nmode != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CK) begin
    if (RN) begin
      chk("model_clk_out", 32'(clk_out), 32'(m_clk));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_ratio_ack", 32'(ratio_ack), 32'(m_ack));
`ifdef CLK_DIV_DRIVER_PERIOD_CNT_EN
      chk("model_period_cnt", 32'(period_cnt), 32'(m_pc));
`endif
      if (ratio_ack === 1'b1) ack_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CK);
  endtask

  task automatic load(input int r);
    div_ratio = DIV_W'(r);
    ratio_ld  = 1'b1;
    tick(1);
    ratio_ld  = 1'b0;
  endtask

  task automatic wait_ack(input string name, input bit need_final);
    bit got = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (ratio_ack === 1'b1 && (!need_final || !m_pv)) begin got = 1; break; end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit got = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (busy === 1'b0) begin got = 1; break; end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  logic [9:0] pat;
  int         acks0;

  initial begin
    tick(3);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ratio_ack), 32'd0);
    RN = 1'b1;
    tick(2);
    chk("idle_clk_out", 32'(clk_out), 32'd0);

    // Default N=2: first high 1 CK after RUN entry, then toggle every CK.
    en = 1'b1;
    tick(1);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_entry_clk", 32'(clk_out), 32'd0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin tick(1); pat = {pat[8:0], clk_out}; end
    chk("n2_wave", 32'(pat[3:0]), 32'b1010);

    // Switch to N=5 while running.
    acks0 = ack_cnt;
    load(5);
    wait_ack("ack5_timeout", 1'b0);
    chk("ack5_clk", 32'(clk_out), 32'd0);
    for (int i = 0; i < 10; i++) begin tick(1); pat = {pat[8:0], clk_out}; end
    chk("n5_wave", 32'(pat), 32'b1100011000);
    chk("ack5_count", 32'(ack_cnt - acks0), 32'd1);

    // Ratios 1 and 0 clamp to 2.
    for (int r = 1; r >= 0; r--) begin
      acks0 = ack_cnt;
      load(r);
      wait_ack("ack_clamp_timeout", 1'b0);
      for (int i = 0; i < 4; i++) begin tick(1); pat = {pat[8:0], clk_out}; end
      chk("clamp_wave", 32'(pat[3:0]), 32'b1010);
      chk("clamp_ack_count", 32'(ack_cnt - acks0), 32'd1);
    end

    // Back-to-back loads 7 then 6; stop mid-high at N=6.
    load(7);
    load(6);
    wait_ack("ack6_timeout", 1'b1);
    tick(1);
    chk("n6_first_high", 32'(clk_out), 32'd1);
    en = 1'b0;
    pat = '0;
    for (int i = 0; i < 5; i++) begin tick(1); pat = {pat[8:0], clk_out}; end
    chk("stop_wave", 32'(pat[4:0]), 32'b11000);
    chk("stop_busy", 32'(busy), 32'd0);
    tick(2);
    chk("stop_idle_clk", 32'(clk_out), 32'd0);

    // Reset mid-high-phase with a ratio pending.
    en = 1'b1;
    tick(3);
    load(3);
    chk("pre_rst_clk", 32'(clk_out), 32'd1);
    acks0 = ack_cnt;
    #1 RN = 1'b0;
    #1;
    chk("async_rst_clk", 32'(clk_out), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge CK);
    RN = 1'b1;
    tick(1);
    pat = '0;
    for (int i = 0; i < 4; i++) begin tick(1); pat = {pat[8:0], clk_out}; end
    chk("post_rst_wave", 32'(pat[3:0]), 32'b1010);
    tick(12);
    chk("post_rst_no_ack", 32'(ack_cnt - acks0), 32'd0);

    // N=4 loaded in IDLE, then 10 full periods.
    en = 1'b0;
    wait_idle("idle_timeout1");
    load(4);
    wait_ack("ack4_timeout", 1'b0);
    en = 1'b1;
    tick(1);
    pat = '0;
    for (int i = 0; i < 8; i++) begin tick(1); pat = {pat[8:0], clk_out}; end
    chk("n4_wave", 32'(pat[7:0]), 32'b11001100);
    tick(32);
`ifdef CLK_DIV_DRIVER_PERIOD_CNT_EN
    chk("period_cnt_10", 32'(period_cnt), 32'd10);
`endif
    en = 1'b0;
    wait_idle("idle_timeout2");
`ifdef CLK_DIV_DRIVER_PERIOD_CNT_EN
    chk("period_cnt_clr", 32'(period_cnt), 32'd0);
`endif
    chk("final_clk", 32'(clk_out), 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/clk_div_driver.md
Name: clk_div_driver

Overview:
- Clock-source counterpart to the clock-load cells: generates a divided, glitch-free clock from CK to drive downstream clock nets and loads.
- Divide ratio and enable are programmable at runtime with a load/acknowledge handshake.
- Ratio and enable changes take effect only on output-period boundaries, so no runt pulses are emitted.
- Sits beside the std-cell clock models as a behavioural clock-tree source for gate-level and cell-level sims.

Parameters:
- DIV_W, 4, width of divide-ratio field; max ratio 2^DIV_W-1.
- RST_RATIO, 2, ratio active out of reset; must be >=2.

Ports:
- CK  input  1  source clock.
- RN  input  1  reset, asynchronous, active-low.
- en  input  1  run request; level-sensitive.
- div_ratio  input  DIV_W  requested divide ratio N; sampled when ratio_ld=1.
- ratio_ld  input  1  one-cycle load strobe for div_ratio.
- ratio_ack  output  1  one-cycle pulse when the pending ratio becomes active.
- clk_out  output  1  divided clock, registered.
- busy  output  1  1 while in RUN or STOP_PEND.

Behaviour:
- Interface: one clock CK; asynchronous active-low reset RN (fixed polarity and synchronicity).
- Reset values:
  - clk_out=0, ratio_ack=0, busy=0.
  - cnt=0, state=IDLE.
  - active ratio = RST_RATIO; pending-valid = 0.
- Ratio clamp: div_ratio values 0 and 1 are clamped to 2 at capture. Active N is always >=2.
- Counter: cnt is DIV_W bits. In RUN/STOP_PEND it increments each CK and wraps from N-1 to 0. "Wrap" means a cycle with cnt==N-1.
- Output waveform:
  - clk_out(t+1) = (state!=IDLE) && (cnt(t) < H), with H = N>>1.
  - High for H cycles, low for N-H cycles; odd N gives the extra cycle low.
  - First rising edge of clk_out occurs 1 CK after entering RUN.
- States:
  - IDLE: cnt held at 0, clk_out=0. en=1 -> RUN next cycle.
  - RUN: en=0 -> STOP_PEND. If en=0 in a wrap cycle -> IDLE directly.
  - STOP_PEND: keep counting. At wrap -> IDLE. en=1 before wrap -> back to RUN; the period is not restarted.
- Ratio handshake:
  - ratio_ld=1 captures the clamped div_ratio into the pending register and sets pending-valid.
  - Pending ratio is applied at the next wrap in RUN/STOP_PEND, or on the next cycle in IDLE.
  - ratio_ack pulses in the cycle after the apply; cnt restarts at 0 with the new N.
- Simultaneous events:
  - ratio_ld in the same cycle as an apply: the new value becomes pending; the old pending value is applied and acked.
  - Repeated ratio_ld before an apply: last value wins; exactly one ack.
- Reset mid-period: clk_out drops to 0 asynchronously. A pending ratio is discarded and no ack is issued.
- clk_out never changes state more than once per CK, and never produces a high phase shorter than H cycles.

Optional Feature:
- Macro: CLK_DIV_DRIVER_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt [15:0], reset 0.
  - Increments at each wrap in RUN/STOP_PEND; wraps 0xFFFF->0.
  - Cleared on entry to IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package clk_div_pkg:
  - state enum {IDLE, RUN, STOP_PEND}.
  - MIN_RATIO=2 constant.
  - Clamp function for the ratio.
- One natural sub-module, clk_div_ratio_hs: pending register, pending-valid flag and ratio_ack generation.
- Counter, FSM and output flop stay in the top.

Test Plan:
- Reset release, en=1, N=2 (default) -> clk_out toggles every CK: 1,0,1,0 starting 1 CK after RUN entry; busy=1.
- ratio_ld with div_ratio=5 while running -> no change until the wrap; ratio_ack one cycle after it; then clk_out high 2 / low 3 cycles repeating.
- div_ratio=1 and 0 loaded -> both clamp to N=2; ratio_ack issued once per apply.
- en=0 mid-high-phase at N=6 -> remaining high and low cycles complete, then IDLE with clk_out=0, busy=0; no pulse shorter than 3 cycles.
- RN asserted mid-period with a ratio pending -> clk_out=0 immediately; after release, N=RST_RATIO and no ratio_ack.
- CLK_DIV_DRIVER_PERIOD_CNT_EN defined, N=4, 10 full periods -> period_cnt=10; en=0 and then IDLE -> period_cnt=0.
